// File: rtl/dm_sized.sv
// dm_sized: MIPS MEM-stage data memory with byte/half/word access on big-endian lanes.
// Byte addressed; loads are asynchronous and sign/zero-extended; illegal requests are
// flagged on misalign and suppressed. Optional wait states are compiled in with the
// DM_WAIT_EN macro; in the default build the memory never stalls.
module dm_sized #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  stall,
    output logic                  misalign
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    // Contents are deliberately left unreset; they read as X until written.
    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  misalign_c;
    logic                  legal;
    logic                  complete;
    logic                  stall_c;
    logic                  we;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           word_rd;
    logic [31:0]           load_val;
    logic [31:0]           merged;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign req      = rd | wr;
    assign word_idx = addr[ADDR_WIDTH-1:2];
    assign lane     = addr[1:0];
    assign legal    = req & ~misalign_c;

    // Illegal size or an address not aligned to the access size.
    always_comb begin
        misalign_c = 1'b0;
        if (req) begin
            case (size)
                2'b00:   misalign_c = 1'b0;
                2'b01:   misalign_c = addr[0];
                2'b10:   misalign_c = (addr[1:0] != 2'b00);
                default: misalign_c = 1'b1;
            endcase
        end
    end

    // Load path: pick the addressed lane(s) of the stored word and extend to 32 bits.
    // Lane 0 is the most significant byte.
    always_comb begin
        word_rd  = mem[word_idx];
        byte_sel = 8'h00;
        half_sel = lane[1] ? word_rd[15:0] : word_rd[31:16];
        case (lane)
            2'd0:    byte_sel = word_rd[31:24];
            2'd1:    byte_sel = word_rd[23:16];
            2'd2:    byte_sel = word_rd[15:8];
            default: byte_sel = word_rd[7:0];
        endcase
        case (size)
            2'b00:   load_val = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            2'b01:   load_val = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            default: load_val = word_rd;
        endcase
    end

    // Store path: splice the right-justified store data into the addressed lane(s).
    always_comb begin
        merged = word_rd;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) merged[15:0]  = wdata[15:0];
                else         merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

`ifdef DM_WAIT_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Wait-state sequencing. The first stalled cycle is spent in IDLE and loads cnt=1,
    // so the access completes in WAIT when cnt reaches WAIT_CYCLES: exactly WAIT_CYCLES
    // stalled cycles, data on the next one. A dropped or illegal request aborts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (legal) begin
                    if (WAIT_N == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                if (!legal) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == WAIT_N) begin
                    complete = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
        endcase
    end

    // Wait-state registers; reset returns to IDLE with the counter cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic wait_cfg_unused;

    assign wait_cfg_unused = (WAIT_CYCLES != 0);
    assign stall_c         = 1'b0;
    assign complete        = legal;
`endif

    assign we = complete & wr & ~rst;

    // Array write at the completing edge; an edge seen while in reset never writes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[word_idx] <= merged;
        end
    end

    // Outputs are forced quiet during reset; load data only in the completing cycle.
    always_comb begin
        stall    = ~rst & stall_c;
        misalign = ~rst & misalign_c;
        rdata    = (~rst & rd & legal & ~stall_c) ? load_val : 32'h0;
    end

endmodule

// File: tb/tb_dm_sized.sv
// Directed bench for dm_sized: lane placement, extension, misalignment, read-during-write
// and, when built with DM_WAIT_EN, wait-state length and reset during a wait.
module tb_dm_sized;

    localparam int AW = 9;
`ifdef DM_WAIT_EN
    localparam int EXP_STALL = 2;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [1:0]    size;
    logic          sign_ext;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          stall;
    logic          misalign;

    int errors = 0;
    int checks = 0;

    dm_sized #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .size     (size),
        .sign_ext (sign_ext),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .misalign (misalign)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request held until it completes (stall low) or a 20-cycle budget runs out.
    task automatic access(input logic r, input logic w, input logic [1:0] sz, input logic se,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          output logic [31:0] rdv, output logic mis, output int stalls);
        @(negedge clk);
        rd = r; wr = w; size = sz; sign_ext = se; addr = a; wdata = wd;
        stalls = 0;
        #1;
        while (stall === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdv = rdata;
        mis = misalign;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic store(input string tag, input logic [1:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] wd);
        logic [31:0] rdv;
        logic        mis;
        int          st;
        access(1'b0, 1'b1, sz, 1'b0, a, wd, rdv, mis, st);
        check({tag, "_st_stall"}, 32'(st), 32'(EXP_STALL));
        check({tag, "_st_mis"}, {31'h0, mis}, 32'h0);
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic se,
                        input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] rdv;
        logic        mis;
        int          st;
        access(1'b1, 1'b0, sz, se, a, 32'h0, rdv, mis, st);
        check({tag, "_data"}, rdv, exp);
        check({tag, "_stall"}, 32'(st), 32'(EXP_STALL));
        check({tag, "_mis"}, {31'h0, mis}, 32'h0);
    endtask

    // Illegal request: flagged, no stall, no data, nothing written.
    task automatic bad(input string tag, input logic r, input logic w, input logic [1:0] sz,
                       input logic [AW-1:0] a, input logic [31:0] wd);
        logic [31:0] rdv;
        logic        mis;
        int          st;
        access(r, w, sz, 1'b1, a, wd, rdv, mis, st);
        check({tag, "_mis"}, {31'h0, mis}, 32'h1);
        check({tag, "_data"}, rdv, 32'h0);
        check({tag, "_stall"}, 32'(st), 32'h0);
    endtask

    initial begin
        logic [31:0] rdv;
        logic        mis;
        int          st;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = 32'h0;

        // Outputs forced quiet in reset even with an illegal load presented.
        @(negedge clk);
        rd = 1'b1; size = 2'b11; addr = 9'h003;
        #1;
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rd = 1'b0; size = 2'b00;
        rst = 1'b0;

        // Word store and load.
        store("t1", 2'b10, 9'h000, 32'hABCDEF01);
        load("t1_lw", 2'b10, 1'b0, 9'h000, 32'hABCDEF01);

        // Byte store into lane 1 leaves other lanes intact.
        store("t2w", 2'b10, 9'h004, 32'h11223344);
        store("t2b", 2'b00, 9'h005, 32'hAAAAAA7F);
        load("t2_lw", 2'b10, 1'b0, 9'h004, 32'h117F3344);
        load("t2_lb", 2'b00, 1'b1, 9'h005, 32'h0000007F);
        load("t2_lb3", 2'b00, 1'b1, 9'h007, 32'h00000044);

        // Sign/zero extension on half and byte loads.
        store("t3", 2'b10, 9'h008, 32'hFFFF8001);
        load("t3_lh_s", 2'b01, 1'b1, 9'h00A, 32'hFFFF8001);
        load("t3_lh_z", 2'b01, 1'b0, 9'h00A, 32'h00008001);
        load("t3_lb_s", 2'b00, 1'b1, 9'h008, 32'hFFFFFFFF);
        load("t3_lb_z", 2'b00, 1'b0, 9'h009, 32'h000000FF);
        load("t3_lh0_z", 2'b01, 1'b0, 9'h008, 32'h0000FFFF);

        // Half store to upper and lower halves.
        store("t3h0", 2'b01, 9'h008, 32'h12341234);
        store("t3h2", 2'b01, 9'h00A, 32'h0000C0DE);
        load("t3h_lw", 2'b10, 1'b0, 9'h008, 32'h1234C0DE);

        // Misaligned / illegal requests are suppressed.
        store("t4pre", 2'b10, 9'h00C, 32'h55667788);
        bad("t4_sw", 1'b0, 1'b1, 2'b10, 9'h00D, 32'hDEADBEEF);
        bad("t4_sh_odd", 1'b0, 1'b1, 2'b01, 9'h00F, 32'hDEADBEEF);
        load("t4_unch", 2'b10, 1'b0, 9'h00C, 32'h55667788);
        bad("t4_lh", 1'b1, 1'b0, 2'b01, 9'h003, 32'h0);
        bad("t4_sz11", 1'b1, 1'b0, 2'b11, 9'h000, 32'h0);
        bad("t4_sz11w", 1'b0, 1'b1, 2'b11, 9'h00C, 32'h99999999);
        load("t4_unch2", 2'b10, 1'b0, 9'h00C, 32'h55667788);

        // Read and write together: old contents visible that cycle, new afterwards.
        access(1'b1, 1'b1, 2'b10, 1'b0, 9'h000, 32'hFEFEFEFE, rdv, mis, st);
        check("t5_rw_data", rdv, 32'hABCDEF01);
        check("t5_rw_stall", 32'(st), 32'(EXP_STALL));
        load("t5_after", 2'b10, 1'b0, 9'h000, 32'hFEFEFEFE);

        // Nothing requested: no data even with a valid address.
        @(negedge clk);
        addr = 9'h000; size = 2'b10;
        #1;
        check("idle_rdata", rdata, 32'h0);
        check("idle_mis", {31'h0, misalign}, 32'h0);

`ifdef DM_WAIT_EN
        // Reset mid-wait on a store: no write, and the next access still waits fully.
        store("t6pre", 2'b10, 9'h010, 32'h0BADF00D);
        @(negedge clk);
        wr = 1'b1; size = 2'b10; addr = 9'h010; wdata = 32'h13572468;
        #1;
        check("t6_stall1", {31'h0, stall}, 32'h1);
        @(negedge clk);
        #1;
        check("t6_stall2", {31'h0, stall}, 32'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_stall", {31'h0, stall}, 32'h0);
        check("t6_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        wr = 1'b0;
        rst = 1'b0;
        load("t6_unch", 2'b10, 1'b0, 9'h010, 32'h0BADF00D);
        load("t6_again", 2'b10, 1'b0, 9'h004, 32'h117F3344);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
